hc_sr04_echo_emulator: RTL

//  Synthesizable model of the sensor end of the HC-SR04 trigger/echo protocol, for hardware-in-loop

---
 rtl/hc_sr04_echo_emulator.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hc_sr04_echo_emulator.sv
// ---------------------------------------------------------------------------
// hc_sr04_echo_emulator
//
// Emulates the sensor side of an HC-SR04 ultrasonic ranger so the rover's
// distance-sensor driver can be exercised without real hardware. A trigger
// pulse of sufficient width is answered, after a fixed burst delay, by an
// echo pulse whose width encodes the programmed distance in centimetres.
//
// Ports
//   clk          clock
//   reset_n      asynchronous active-low reset (released synchronously inside)
//   sn_trigger   trigger pin from the driver, asynchronous to clk
//   sn_edge      echo pin back to the driver
//   distance_ld  one-cycle strobe: capture distance_in into the shadow register
//   distance_in  distance to emulate, cm
//   busy         high from trigger acceptance until the echo falls
//   trig_err     one-cycle pulse when a trigger was too short and rejected
//   echo_done    one-cycle pulse on the cycle the echo falls
// ---------------------------------------------------------------------------
module hc_sr04_echo_emulator #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int TRIG_MIN_US     = 10,
    parameter int ECHO_DELAY_US   = 250,
    parameter int US_PER_CM       = 58,
    parameter int MAX_DISTANCE_CM = 400,
    parameter int TIMEOUT_US      = 38000,
    parameter int WL              = $clog2(MAX_DISTANCE_CM + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sn_trigger,
    output logic          sn_edge,
    input  logic          distance_ld,
    input  logic [WL-1:0] distance_in,
    output logic          busy,
    output logic          trig_err,
    output logic          echo_done
);

    localparam int CLK_PER_US  = CLK_FREQ / 1_000_000;
    localparam int TRIG_CNT    = TRIG_MIN_US * CLK_PER_US;
    localparam int DLY_CNT     = ECHO_DELAY_US * CLK_PER_US;
    localparam int CYC_PER_CM  = US_PER_CM * CLK_PER_US;
    localparam int TIMEOUT_CNT = TIMEOUT_US * CLK_PER_US;
    localparam int MAXDIST_CNT = MAX_DISTANCE_CM * CYC_PER_CM;
    localparam int ECHO_MAX    = (TIMEOUT_CNT > MAXDIST_CNT) ? TIMEOUT_CNT : MAXDIST_CNT;
    localparam int CNT_MAX     = (ECHO_MAX > DLY_CNT) ? ECHO_MAX : DLY_CNT;
    // One spare bit so the largest echo product can never wrap.
    localparam int CW          = $clog2(CNT_MAX) + 1;
    localparam int TW          = $clog2(TRIG_CNT + 1);

    localparam logic [CW-1:0] CYC_PER_CM_W = CW'(CYC_PER_CM);
    localparam logic [CW-1:0] TIMEOUT_W    = CW'(TIMEOUT_CNT);
    localparam logic [CW-1:0] DLY_W        = CW'(DLY_CNT);
    localparam logic [TW-1:0] TRIG_W       = TW'(TRIG_CNT);
    localparam logic [WL-1:0] MAXDIST_W    = WL'(MAX_DISTANCE_CM);

    typedef enum logic [1:0] {
        IDLE,
        TRIG_HI,
        DELAY,
        ECHO
    } state_t;

    logic [1:0]    rst_sync;
    logic          rst_n_int;
    logic          trig_s1, trig_s2, trig_d;
    logic          trig_rise, trig_fall;
    logic [WL-1:0] shadow_dist;
    logic          dist_valid;
    logic [CW-1:0] echo_prod;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] echo_len, echo_len_nxt;
    logic [TW-1:0] width, width_nxt;
    logic          sn_edge_nxt, busy_nxt, trig_err_nxt, echo_done_nxt;

    // Reset bridge: assertion reaches every flop immediately (so a reset in
    // the middle of an echo drops the pin at once), release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // Two-flop synchronizer on the trigger pin plus a delayed copy so rising
    // and falling edges are seen exactly once on the synchronized value.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= sn_trigger;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign trig_rise = trig_s2 & ~trig_d;
    assign trig_fall = ~trig_s2 & trig_d;

    // Shadow distance can be rewritten at any time; a measurement in flight
    // keeps the width it captured when its trigger was accepted.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            shadow_dist <= '0;
        end else if (distance_ld) begin
            shadow_dist <= distance_in;
        end
    end

    // Out-of-range distances (0 or beyond the sensor's reach) report the
    // "no object" timeout instead of a scaled width.
    assign dist_valid = (shadow_dist != '0) && (shadow_dist <= MAXDIST_W);
    assign echo_prod  = CW'(shadow_dist) * CYC_PER_CM_W;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state     <= IDLE;
            cnt       <= '0;
            echo_len  <= '0;
            width     <= '0;
            sn_edge   <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
            echo_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            echo_len  <= echo_len_nxt;
            width     <= width_nxt;
            sn_edge   <= sn_edge_nxt;
            busy      <= busy_nxt;
            trig_err  <= trig_err_nxt;
            echo_done <= echo_done_nxt;
        end
    end

    // Next-state logic. The one down-counter serves both the burst delay and
    // the echo width; triggers outside IDLE/TRIG_HI are simply not looked at.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        echo_len_nxt  = echo_len;
        width_nxt     = width;
        sn_edge_nxt   = sn_edge;
        busy_nxt      = busy;
        trig_err_nxt  = 1'b0;
        echo_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (trig_rise) begin
                    state_nxt = TRIG_HI;
                    width_nxt = TW'(1);
                end
            end

            TRIG_HI: begin
                if (trig_fall) begin
                    if (width >= TRIG_W) begin
                        echo_len_nxt = dist_valid ? echo_prod : TIMEOUT_W;
                        cnt_nxt      = DLY_W;
                        busy_nxt     = 1'b1;
                        state_nxt    = DELAY;
                    end else begin
                        trig_err_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end
                end else if (width < TRIG_W) begin
                    width_nxt = width + TW'(1);
                end
            end

            DELAY: begin
                if (cnt == '0) begin
                    sn_edge_nxt = 1'b1;
                    cnt_nxt     = echo_len - CW'(1);
                    state_nxt   = ECHO;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            ECHO: begin
                if (cnt == '0) begin
                    sn_edge_nxt   = 1'b0;
                    busy_nxt      = 1'b0;
                    echo_done_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
